// File: rtl/rs_encoder.sv
// Systematic RS(K+NPAR,K) encoder over GF(256), poly 0x11D.
// Message symbols pass through; NPAR parity symbols follow from an LFSR.
module rs_encoder #(
  parameter int K    = 24,
  parameter int NPAR = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_in_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  input  logic       i_ready
);

  localparam int CMAX = (K > NPAR) ? K : NPAR;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] P_LAST = CW'(NPAR - 1);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction

  // g[j] is the x^j coefficient of prod(x + alpha^i)
  function automatic logic [NPAR:0][7:0] gen_poly();
    logic [NPAR:0][7:0] g;
    logic [7:0]         root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--)
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g;
  endfunction

  localparam logic [NPAR:0][7:0] G = gen_poly();

  typedef enum logic {
    MSG,
    PAR
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NPAR-1:0][7:0] r_q, r_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 fr;
  logic [7:0]           fb;

  assign fr         = !valid_q || i_ready;
  assign o_in_ready = (state_q == MSG) && fr;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    fb      = i_data ^ r_q[NPAR-1];
    if (fr) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    unique case (state_q)
      MSG: begin
        if (i_valid && fr) begin
          data_d  = i_data;
          valid_d = 1'b1;
          r_d[0]  = gf_mul(fb, G[0]);
          for (int j = 1; j < NPAR; j++)
            r_d[j] = r_q[j-1] ^ gf_mul(fb, G[j]);
          if (cnt_q == K_LAST) begin
            cnt_d   = '0;
            state_d = PAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (fr) begin
          data_d  = r_q[NPAR-1];
          valid_d = 1'b1;
          r_d[0]  = 8'h00;
          for (int j = 1; j < NPAR; j++)
            r_d[j] = r_q[j-1];
          if (cnt_q == P_LAST) begin
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = MSG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = MSG;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= MSG;
      cnt_q   <= '0;
      r_q     <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder: long-division model,
// syndrome check per codeword, stalls, reset abort, back-to-back.
module tb_rs_encoder;

  localparam int K    = 24;
  localparam int NPAR = 4;
  localparam int N    = K + NPAR;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_ready = 1'b1;
  logic       o_in_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;

  always #5 i_clk = ~i_clk;

  rs_encoder #(.K(K), .NPAR(NPAR)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_in_ready (o_in_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .i_ready    (i_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0] sbq[$];
  logic [7:0] cw_buf[$];
  bit         stall_en = 1'b0;
  int         waits = 0;
  int         run = 0;
  int         max_run = 0;
  bit         prev_stall = 1'b0;
  logic       prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // generator, highest degree first
  logic [7:0] gd [NPAR+1];
  initial gd = '{8'h01, 8'h0f, 8'h36, 8'h78, 8'h40};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = xt(p);
      if (b[i]) p ^= a;
    end
    return p;
  endfunction

  task automatic push_cw(input logic [7:0] c [N], input int cnt);
    for (int i = 0; i < cnt; i++)
      sbq.push_back({(i == N - 1), c[i]});
  endtask

  task automatic model(input logic [7:0] m [K], output logic [7:0] c [N]);
    logic [7:0] w [N];
    logic [7:0] q;
    for (int i = 0; i < N; i++) w[i] = (i < K) ? m[i] : 8'h00;
    for (int i = 0; i < K; i++) begin
      q = w[i];
      for (int j = 1; j <= NPAR; j++) w[i+j] ^= gmul(gd[j], q);
    end
    for (int i = 0; i < N; i++) c[i] = (i < K) ? m[i] : w[i];
  endtask

  task automatic send_sym(input logic [7:0] d, input int gap);
    int t;
    t = 0;
    i_valid = 1'b1;
    i_data  = d;
    forever begin
      @(negedge i_clk);
      if (o_in_ready) break;
      waits++;
      t++;
      if (t > 300) begin
        check("in_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (gap) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_msg(input logic [7:0] m [K], input int cnt,
                          input int maxgap);
    for (int i = 0; i < cnt; i++)
      send_sym(m[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 1000) begin
      @(posedge i_clk);
      t++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic t2_vec(input logic [7:0] lastsym, output logic [7:0] m [K],
                        output logic [7:0] c [N]);
    for (int i = 0; i < K; i++) m[i] = 8'h00;
    m[K-1] = lastsym;
    for (int i = 0; i < K; i++) c[i] = m[i];
    if (lastsym == 8'h01) begin
      c[24] = 8'h0f; c[25] = 8'h36; c[26] = 8'h78; c[27] = 8'h40;
    end else begin
      c[24] = 8'h1e; c[25] = 8'h6c; c[26] = 8'hf0; c[27] = 8'h80;
    end
  endtask

  // i_ready driver
  initial forever begin
    @(posedge i_clk);
    #1;
    i_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // output monitor / scoreboard
  initial forever begin
    logic [8:0] e;
    logic [7:0] s;
    logic [7:0] root;
    @(negedge i_clk);
    if (prev_stall)
      check("hold", 32'({o_valid, o_last, o_data}),
            32'({1'b1, prev_last, prev_data}));
    prev_stall = o_valid && !i_ready;
    prev_last  = o_last;
    prev_data  = o_data;
    run = o_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (o_valid && i_ready) begin
      if (sbq.size() == 0) begin
        check("extra_sym", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        check("sym", 32'({o_last, o_data}), 32'(e));
        cw_buf.push_back(o_data);
        if (e[8]) begin
          check("cw_len", 32'(cw_buf.size()), 32'(N));
          root = 8'h01;
          for (int i = 0; i < NPAR; i++) begin
            s = 8'h00;
            foreach (cw_buf[j]) s = gmul(s, root) ^ cw_buf[j];
            check($sformatf("syn%0d", i), 32'(s), 32'd0);
            root = xt(root);
          end
          cw_buf.delete();
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m [K];
    logic [7:0] c [N];
    logic [7:0] msgs [4][K];

    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_out", 32'({o_valid, o_last, o_data}), 32'd0);
    check("rst_rdy", 32'(o_in_ready), 32'd1);

    // T1: all-zero message
    for (int i = 0; i < K; i++) m[i] = 8'h00;
    model(m, c);
    push_cw(c, N);
    send_msg(m, K, 0);
    drain();

    // T2: single nonzero last symbol, hand-derived parity
    t2_vec(8'h01, m, c);
    push_cw(c, N);
    send_msg(m, K, 0);
    t2_vec(8'h02, m, c);
    push_cw(c, N);
    send_msg(m, K, 0);
    drain();

    // T3: random messages
    foreach (msgs[i, j]) msgs[i][j] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      model(msgs[i], c);
      push_cw(c, N);
      send_msg(msgs[i], K, 0);
    end
    drain();

    // T4: same messages under stalls and gaps
    stall_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model(msgs[i], c);
      push_cw(c, N);
      send_msg(msgs[i], K, 3);
    end
    drain();
    stall_en = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    // T5: reset after symbol 10, then clean T2 codeword
    t2_vec(8'h01, m, c);
    push_cw(c, 10);
    send_msg(m, 10, 0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("t5_valid", 32'(o_valid), 32'd0);
    check("t5_rdy", 32'(o_in_ready), 32'd1);
    cw_buf.delete();
    push_cw(c, N);
    send_msg(m, K, 0);
    drain();

    // T6: three back-to-back codewords
    waits   = 0;
    max_run = 0;
    for (int i = 0; i < 3; i++) begin
      model(msgs[i+1], c);
      push_cw(c, N);
      send_msg(msgs[i+1], K, 0);
    end
    drain();
    check("t6_run", 32'(max_run), 32'(3 * N));
    check("t6_par_slots", 32'(waits), 32'(2 * NPAR));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
